// File: rtl/spc2_cfg_pkg.sv
// Shared constants for the spc2 configuration transmitter: field map, default width, FSM states.
// SPC2_CFG_PARITY_EN adds a trailing odd-parity bit to every frame.
package spc2_cfg_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Field positions inside the configuration word as seen by spc2
    localparam int F_LSB  = 12;
    localparam int F_W    = 4;
    localparam int IQ_BIT = 11;
    localparam int GS_LSB = 7;
    localparam int GS_W   = 4;
    localparam int CE_BIT = 6;
    localparam int NS_BIT = 5;
    localparam int GD_LSB = 2;
    localparam int GD_W   = 3;
    localparam int FS_BIT = 1;
    localparam int RE_BIT = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOW   = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    function automatic int frame_len(input int width);
`ifdef SPC2_CFG_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/spc2_half_timer.sv
// Counts HALF system-clock cycles and flags the last one; restart pins the count at zero.
module spc2_half_timer #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int PW = $clog2(HALF + 1);
    localparam logic [PW-1:0] LAST = PW'(HALF - 1);

    logic [PW-1:0] phase_cnt;

    assign tick = (phase_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || restart || tick)
            phase_cnt <= '0;
        else
            phase_cnt <= phase_cnt + 1'b1;
    end

endmodule

// File: rtl/spc2_cfg_tx.sv
// Serial configuration transmitter: shifts one word MSB-first on Sclk, then pulses Cfg_latch.
// Define SPC2_CFG_PARITY_EN to append an odd-parity bit after the LSB.
module spc2_cfg_tx
    import spc2_cfg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int HALF  = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Cfg_word,
    input  logic             Cfg_valid,
    output logic             Cfg_ready,
    output logic             Cfg_out,
    output logic             Sclk,
    output logic             Cfg_latch,
    output logic             Busy
);

    localparam int N  = frame_len(WIDTH);
    localparam int BW = $clog2(WIDTH + 2);

    logic [1:0]    state;
    logic [N-1:0]  shift_reg;
    logic [N-1:0]  frame_word;
    logic [BW-1:0] bit_cnt;
    logic          sclk_r;
    logic          cfg_out_r;
    logic          latch_r;
    logic          tick;
    logic          restart;

`ifdef SPC2_CFG_PARITY_EN
    assign frame_word = {Cfg_word, ~^Cfg_word};
`else
    assign frame_word = Cfg_word;
`endif

    // Phase timer is held at zero outside LOW/HIGH so each frame starts on a clean phase
    assign restart = (state == ST_IDLE) || (state == ST_LATCH);

    spc2_half_timer #(.HALF(HALF)) u_timer (
        .clk     (Clk),
        .reset   (Reset),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            sclk_r    <= 1'b0;
            cfg_out_r <= 1'b0;
            latch_r   <= 1'b0;
        end else begin
            latch_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Cfg_valid) begin
                        shift_reg <= frame_word;
                        bit_cnt   <= BW'(N);
                        cfg_out_r <= frame_word[N-1];
                        state     <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tick) begin
                        sclk_r <= 1'b1;
                        state  <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // Data only moves together with the falling Sclk edge
                    if (tick) begin
                        sclk_r <= 1'b0;
                        if (bit_cnt == BW'(1)) begin
                            bit_cnt   <= '0;
                            cfg_out_r <= 1'b0;
                            latch_r   <= 1'b1;
                            state     <= ST_LATCH;
                        end else begin
                            bit_cnt   <= bit_cnt - BW'(1);
                            shift_reg <= {shift_reg[N-2:0], 1'b0};
                            cfg_out_r <= shift_reg[N-2];
                            state     <= ST_LOW;
                        end
                    end
                end
                ST_LATCH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Cfg_ready = (state == ST_IDLE) && !Reset;
    assign Busy      = (state != ST_IDLE);
    assign Cfg_out   = cfg_out_r;
    assign Sclk      = sclk_r;
    assign Cfg_latch = latch_r;

endmodule

// File: doc/spc2_cfg_tx.md
# spc2_cfg_tx

Upstream serial configuration transmitter for `spc2`. Accepts one 16-bit parallel configuration word over a valid/ready handshake and shifts it out MSB-first on a divided serial clock, then issues a one-cycle latch strobe. Its `Cfg_out` drives `spc2`'s `Cfg_in`; the host-side controller supplies the word.

## Interface
- `WIDTH`, 16: configuration word length in bits; ≥2.
- `HALF`, 2: system-clock cycles per `Sclk` half-period; ≥1.

- `Clk`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Cfg_word`  in  WIDTH  configuration word. Field map: F[3:0]=15:12, IQ=11, GS[3:0]=10:7, CE=6, NS=5, GD[2:0]=4:2, FS=1, RE=0.
- `Cfg_valid`  in  1  word present.
- `Cfg_ready`  out  1  block idle, can accept.
- `Cfg_out`  out  1  serial data to `spc2` `Cfg_in`.
- `Sclk`  out  1  serial clock; receiver samples `Cfg_out` on rising edge.
- `Cfg_latch`  out  1  one-cycle pulse after last bit.
- `Busy`  out  1  frame in progress (inverse of `Cfg_ready` outside reset).

## Operation
- FSM states: IDLE, LOW, HIGH, LATCH.
- IDLE: `Cfg_ready`=1. On `Cfg_valid && Cfg_ready`, capture `Cfg_word` into shift register, load bit counter with frame length N (WIDTH, or WIDTH+1 with parity), go LOW. Later changes to `Cfg_word` ignored.
- LOW: `Sclk`=0, `Cfg_out`=shift-register MSB, held HALF cycles, then HIGH.
- HIGH: `Sclk`=1, data unchanged, held HALF cycles. At end: counter decrements; if zero go LATCH, else shift left by one, go LOW (data changes only while `Sclk` falls).
- LATCH: `Cfg_latch`=1 for exactly one cycle, `Sclk`=0, then IDLE.
- `Cfg_valid` while not ready: ignored, no queueing. Valid held continuously: next frame accepted in the IDLE cycle after LATCH (1-cycle gap).
- Phase counter width: clog2(HALF+1); bit counter: clog2(WIDTH+2).

## Timing
- Reset values (Reset high): state IDLE, `Sclk`=0, `Cfg_out`=0, `Cfg_latch`=0, `Busy`=0, `Cfg_ready`=0 (gated by Reset); `Cfg_ready`=1 first cycle after release.
- Accept at edge t0: `Busy`=1, `Cfg_out`=MSB from t0+1; first `Sclk` rise at t0+1+HALF.
- Each bit occupies 2·HALF cycles; `Cfg_latch` high in cycle t0+1+2·HALF·N; `Cfg_ready` high the following cycle.
- Reset mid-frame: abort at next edge, all outputs to reset values, no `Cfg_latch`.
- `Cfg_out` and `Sclk` registered; no combinational path from inputs to outputs except `Cfg_ready` reset gating.

## Configuration
- `SPC2_CFG_PARITY_EN` defined: N=WIDTH+1; after the LSB one extra bit = odd parity (~^captured word), same LOW/HIGH timing, then LATCH.
- Undefined: N=WIDTH, no parity bit, no parity logic.

## Structure
- Package `spc2_cfg_pkg`: field offset/width constants (F, IQ, GS, CE, NS, GD, FS, RE), default WIDTH, FSM state enum.
- One sub-module `spc2_half_timer`: HALF-cycle phase counter producing an end-of-phase tick, restartable on state entry.

## Test plan
- Reset held 5 cycles, released -> all outputs 0 during reset; `Cfg_ready`=1 first cycle after.
- HALF=2, word 16'hA5C3 accepted -> `Cfg_out` at 16 `Sclk` rises = 1010010111000011; `Cfg_latch` at t0+65, `Cfg_ready` at t0+66.
- `SPC2_CFG_PARITY_EN`, word 16'hA5C3 (8 ones) -> 17th bit = 1; latch at t0+69.
- `Cfg_valid` held high with 16'h0001 then 16'h8000 -> two frames, exactly one idle cycle between; `Cfg_word` change mid-frame ignored.
- Reset asserted during bit 7 -> `Sclk`/`Cfg_out` 0 next cycle, no `Cfg_latch`, new word accepted normally afterward.
- HALF=1, word 16'hFFFF -> `Sclk` toggles every cycle, `Cfg_out` constant 1, latch at t0+33.
